// File: rtl/tap_pkg.sv
// rtl/tap_pkg.sv - shared TAP state encodings, opcodes and next-state helper
package tap_pkg;

  localparam int IR_WIDTH_DEFAULT = 4;

  // Instruction opcodes; any other code selects BYPASS
  localparam int OPC_EXTEST = 0;
  localparam int OPC_SAMPLE = 1;
  localparam int OPC_IDCODE = 2;

  // Fixed IEEE 1149.1 state encoding, visible on TapState
  typedef enum logic [3:0] {
    TAP_EX2DR = 4'h0,
    TAP_EX1DR = 4'h1,
    TAP_SHDR  = 4'h2,
    TAP_PAUDR = 4'h3,
    TAP_SELIR = 4'h4,
    TAP_UPDDR = 4'h5,
    TAP_CAPDR = 4'h6,
    TAP_SELDR = 4'h7,
    TAP_EX2IR = 4'h8,
    TAP_EX1IR = 4'h9,
    TAP_SHIR  = 4'hA,
    TAP_PAUIR = 4'hB,
    TAP_RTI   = 4'hC,
    TAP_UPDIR = 4'hD,
    TAP_CAPIR = 4'hE,
    TAP_TLR   = 4'hF
  } tap_state_e;

  // Standard TMS-driven successor of a TAP state
  function automatic tap_state_e tap_next_state(input tap_state_e s, input logic tms);
    tap_state_e n;
    case (s)
      TAP_TLR:   n = tms ? TAP_TLR   : TAP_RTI;
      TAP_RTI:   n = tms ? TAP_SELDR : TAP_RTI;
      TAP_SELDR: n = tms ? TAP_SELIR : TAP_CAPDR;
      TAP_CAPDR: n = tms ? TAP_EX1DR : TAP_SHDR;
      TAP_SHDR:  n = tms ? TAP_EX1DR : TAP_SHDR;
      TAP_EX1DR: n = tms ? TAP_UPDDR : TAP_PAUDR;
      TAP_PAUDR: n = tms ? TAP_EX2DR : TAP_PAUDR;
      TAP_EX2DR: n = tms ? TAP_UPDDR : TAP_SHDR;
      TAP_UPDDR: n = tms ? TAP_SELDR : TAP_RTI;
      TAP_SELIR: n = tms ? TAP_TLR   : TAP_CAPIR;
      TAP_CAPIR: n = tms ? TAP_EX1IR : TAP_SHIR;
      TAP_SHIR:  n = tms ? TAP_EX1IR : TAP_SHIR;
      TAP_EX1IR: n = tms ? TAP_UPDIR : TAP_PAUIR;
      TAP_PAUIR: n = tms ? TAP_EX2IR : TAP_PAUIR;
      TAP_EX2IR: n = tms ? TAP_UPDIR : TAP_SHIR;
      TAP_UPDIR: n = tms ? TAP_SELDR : TAP_RTI;
      default:   n = TAP_TLR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/tap_controller.sv
// rtl/tap_controller.sv - IEEE 1149.1 TAP controller with IR, IDCODE, bypass and BSR control
module tap_controller
  import tap_pkg::*;
#(
  parameter int          IR_WIDTH   = IR_WIDTH_DEFAULT,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
  input  logic                ClockTAP,
  input  logic                Rst,
  input  logic                TMS,
  input  logic                TDI,
  input  logic                BSRSOUT,
  output logic                TDO,
  output logic                TDOEn,
  output logic                ShiftBR,
  output logic                ClockBREn,
  output logic                UpdateBR,
  output logic                ModeControl,
  output logic [3:0]          TapState,
  output logic [IR_WIDTH-1:0] IRValue
);

  localparam logic [IR_WIDTH-1:0] IR_EXTEST  = IR_WIDTH'(OPC_EXTEST);
  localparam logic [IR_WIDTH-1:0] IR_SAMPLE  = IR_WIDTH'(OPC_SAMPLE);
  localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(OPC_IDCODE);
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);

  tap_state_e          state_q, state_d;
  logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic [31:0]         id_q, id_d;
  logic                bypass_q, bypass_d;
  logic                shift_br_q, shift_br_d;
  logic                clock_br_en_q, clock_br_en_d;
  logic                update_br_q, update_br_d;
  logic                mode_q, mode_d;
  logic                bsr_sel;
  logic                id_sel;
  logic                tdo_en;
  logic                tdo;

  // Instruction decode from the active IR
  always_comb begin
    bsr_sel = (ir_q == IR_EXTEST) || (ir_q == IR_SAMPLE);
    id_sel  = (ir_q == IR_IDCODE);
  end

  // TAP next-state
  always_comb begin
    state_d = tap_next_state(state_q, TMS);
  end

  // IR shift register and active instruction; TLR entry forces IDCODE
  always_comb begin
    ir_sr_d = ir_sr_q;
    ir_d    = ir_q;
    case (state_q)
      TAP_CAPIR: ir_sr_d = IR_CAPTURE;
      TAP_SHIR:  ir_sr_d = {TDI, ir_sr_q[IR_WIDTH-1:1]};
      default:   ir_sr_d = ir_sr_q;
    endcase
    if (state_d == TAP_TLR) begin
      ir_d = IR_IDCODE;
    end else if (state_q == TAP_UPDIR) begin
      ir_d = ir_sr_q;
    end
  end

  // Data registers: bypass always tracks the DR path, ID only when selected
  always_comb begin
    bypass_d = bypass_q;
    id_d     = id_q;
    case (state_q)
      TAP_CAPDR: begin
        bypass_d = 1'b0;
        if (id_sel) id_d = IDCODE_VAL;
      end
      TAP_SHDR: begin
        bypass_d = TDI;
        if (id_sel) id_d = {TDI, id_q[31:1]};
      end
      default: begin
        bypass_d = bypass_q;
        id_d     = id_q;
      end
    endcase
  end

  // Boundary-scan controls decoded from next state so the flops give clean edges
  always_comb begin
    shift_br_d    = (state_d == TAP_SHDR) && bsr_sel;
    clock_br_en_d = ((state_d == TAP_CAPDR) || (state_d == TAP_SHDR)) && bsr_sel;
    update_br_d   = (state_d == TAP_UPDDR) && bsr_sel;
    mode_d        = (ir_d == IR_EXTEST);
  end

  // Serial output mux; driven low whenever not shifting
  always_comb begin
    tdo_en = (state_q == TAP_SHDR) || (state_q == TAP_SHIR);
    tdo    = 1'b0;
    if (state_q == TAP_SHIR) begin
      tdo = ir_sr_q[0];
    end else if (state_q == TAP_SHDR) begin
      if (bsr_sel)     tdo = BSRSOUT;
      else if (id_sel) tdo = id_q[0];
      else             tdo = bypass_q;
    end
  end

  // State register
  always_ff @(posedge ClockTAP or posedge Rst) begin
    if (Rst) state_q <= TAP_TLR;
    else     state_q <= state_d;
  end

  // Instruction registers
  always_ff @(posedge ClockTAP or posedge Rst) begin
    if (Rst) begin
      ir_sr_q <= '0;
      ir_q    <= IR_IDCODE;
    end else begin
      ir_sr_q <= ir_sr_d;
      ir_q    <= ir_d;
    end
  end

  // Data registers
  always_ff @(posedge ClockTAP or posedge Rst) begin
    if (Rst) begin
      id_q     <= '0;
      bypass_q <= 1'b0;
    end else begin
      id_q     <= id_d;
      bypass_q <= bypass_d;
    end
  end

  // Registered boundary-scan controls
  always_ff @(posedge ClockTAP or posedge Rst) begin
    if (Rst) begin
      shift_br_q    <= 1'b0;
      clock_br_en_q <= 1'b0;
      update_br_q   <= 1'b0;
      mode_q        <= 1'b0;
    end else begin
      shift_br_q    <= shift_br_d;
      clock_br_en_q <= clock_br_en_d;
      update_br_q   <= update_br_d;
      mode_q        <= mode_d;
    end
  end

  assign TDO         = tdo;
  assign TDOEn       = tdo_en;
  assign ShiftBR     = shift_br_q;
  assign ClockBREn   = clock_br_en_q;
  assign UpdateBR    = update_br_q;
  assign ModeControl = mode_q;
  assign TapState    = state_q;
  assign IRValue     = ir_q;

endmodule

// File: tb/tb_tap_controller.sv
// tb/tb_tap_controller.sv - self-checking bench for tap_controller
module tb_tap_controller;

  localparam int W = 4;

  logic         ClockTAP = 1'b0;
  logic         Rst      = 1'b0;
  logic         TMS      = 1'b1;
  logic         TDI      = 1'b0;
  logic         BSRSOUT  = 1'b0;
  logic         TDO, TDOEn, ShiftBR, ClockBREn, UpdateBR, ModeControl;
  logic [3:0]   TapState;
  logic [W-1:0] IRValue;

  int n_chk  = 0;
  int n_fail = 0;

  tap_controller #(.IR_WIDTH(W), .IDCODE_VAL(32'h1000_0001)) dut (
    .ClockTAP(ClockTAP), .Rst(Rst), .TMS(TMS), .TDI(TDI), .BSRSOUT(BSRSOUT),
    .TDO(TDO), .TDOEn(TDOEn), .ShiftBR(ShiftBR), .ClockBREn(ClockBREn),
    .UpdateBR(UpdateBR), .ModeControl(ModeControl), .TapState(TapState),
    .IRValue(IRValue)
  );

  always #5 ClockTAP = ~ClockTAP;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Successor tables indexed by state code, straight from the 1149.1 diagram
  logic [3:0] nxt0 [16] = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
                            4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
  logic [3:0] nxt1 [16] = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
                            4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};

  // Behavioural model
  logic [3:0]   m_state = 4'hF;
  logic [W-1:0] m_ir    = W'(2);
  logic [W-1:0] m_irsr  = '0;
  logic [31:0]  m_id    = '0;
  logic         m_byp   = 1'b0;

  function automatic bit is_bsr(input logic [W-1:0] ir);
    return (ir == W'(0)) || (ir == W'(1));
  endfunction

  always @(posedge ClockTAP or posedge Rst) begin
    logic [3:0]   ns;
    logic [W-1:0] old_sr;
    if (Rst) begin
      m_state = 4'hF; m_ir = W'(2); m_irsr = '0; m_id = '0; m_byp = 1'b0;
    end else begin
      ns = TMS ? nxt1[m_state] : nxt0[m_state];
      old_sr = m_irsr;
      if (m_state == 4'hE) m_irsr = W'(1);
      if (m_state == 4'hA) m_irsr = (m_irsr >> 1) | (W'(TDI) << (W-1));
      if (m_state == 4'h6) begin
        m_byp = 1'b0;
        if (m_ir == W'(2)) m_id = 32'h1000_0001;
      end
      if (m_state == 4'h2) begin
        m_byp = TDI;
        if (m_ir == W'(2)) m_id = (m_id >> 1) | (32'(TDI) << 31);
      end
      if (ns == 4'hF) m_ir = W'(2);
      else if (m_state == 4'hD) m_ir = old_sr;
      m_state = ns;
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge ClockTAP) begin
    logic exp_tdo;
    logic bsr;
    bsr = is_bsr(m_ir);
    exp_tdo = 1'b0;
    if (m_state == 4'hA) exp_tdo = m_irsr[0];
    else if (m_state == 4'h2) exp_tdo = bsr ? BSRSOUT : ((m_ir == W'(2)) ? m_id[0] : m_byp);
    chk("tapstate", 32'(TapState), 32'(m_state));
    chk("irvalue", 32'(IRValue), 32'(m_ir));
    chk("tdo", 32'(TDO), 32'(exp_tdo));
    chk("tdoen", 32'(TDOEn), 32'((m_state == 4'h2) || (m_state == 4'hA)));
    chk("shiftbr", 32'(ShiftBR), 32'((m_state == 4'h2) && bsr));
    chk("clockbren", 32'(ClockBREn), 32'(((m_state == 4'h2) || (m_state == 4'h6)) && bsr));
    chk("updatebr", 32'(UpdateBR), 32'((m_state == 4'h5) && bsr));
    chk("modecontrol", 32'(ModeControl), 32'(m_ir == W'(0)));
  end

  logic last_tdo, last_tdoen, last_bsr;
  int   cnt_clk, cnt_shift, cnt_upd;

  task automatic clr_counts();
    cnt_clk = 0; cnt_shift = 0; cnt_upd = 0;
  endtask

  task automatic step(input bit tms, input bit tdi);
    TMS = tms; TDI = tdi; BSRSOUT = 1'($urandom_range(0, 1));
    #2;
    last_tdo = TDO; last_tdoen = TDOEn; last_bsr = BSRSOUT;
    @(posedge ClockTAP); #1;
    cnt_clk += int'(ClockBREn); cnt_shift += int'(ShiftBR); cnt_upd += int'(UpdateBR);
  endtask

  task automatic load_ir(input logic [W-1:0] v, output logic [W-1:0] tdo_bits);
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < W; i++) begin
      step(i == W-1, v[i]);
      tdo_bits[i] = last_tdo;
    end
    step(1, 0); step(0, 0);
  endtask

  task automatic dr_scan(input int n, input logic [31:0] tdi_bits,
                         output logic [31:0] tdo_bits, output int bsr_mis, output int en_low);
    bsr_mis = 0; en_low = 0; tdo_bits = '0;
    step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < n; i++) begin
      step(i == n-1, tdi_bits[i]);
      tdo_bits[i] = last_tdo;
      if (last_tdo !== last_bsr) bsr_mis++;
      if (last_tdoen !== 1'b1) en_low++;
    end
    step(1, 0); step(0, 0);
  endtask

  initial begin
    logic [W-1:0] irb;
    logic [31:0]  dro;
    int           mis, enl;

    #1 Rst = 1'b1;
    #3;
    chk("rst_state", 32'(TapState), 32'hF);
    chk("rst_ir", 32'(IRValue), 32'h2);
    chk("rst_outs", {26'd0, TDO, TDOEn, ShiftBR, ClockBREn, UpdateBR, ModeControl}, 32'h0);
    @(posedge ClockTAP); #1;
    Rst = 1'b0;

    // TMS=1 x5 from RTI
    step(0, 0);
    for (int i = 0; i < 5; i++) step(1, 0);
    chk("tms5_state", 32'(TapState), 32'hF);
    chk("tms5_ir", 32'(IRValue), 32'h2);
    chk("tms5_brs", {28'd0, ShiftBR, ClockBREn, UpdateBR, ModeControl}, 32'h0);

    // IDCODE read
    step(0, 0);
    clr_counts();
    dr_scan(32, $urandom, dro, mis, enl);
    chk("idcode_word", dro, 32'h1000_0001);
    chk("idcode_tdoen", 32'(enl), 32'd0);
    chk("idcode_br_clk", 32'(cnt_clk), 32'd0);

    // CapIR then ShIR x4 gives 1,0,0,0; load EXTEST
    load_ir(4'b0000, irb);
    chk("capir_tdo", 32'(irb), 32'h1);
    chk("extest_ir", 32'(IRValue), 32'h0);
    chk("extest_mode", 32'(ModeControl), 32'h1);
    clr_counts();
    dr_scan(6, $urandom, dro, mis, enl);
    chk("extest_clkbren", 32'(cnt_clk), 32'd7);
    chk("extest_shiftbr", 32'(cnt_shift), 32'd6);
    chk("extest_updbr", 32'(cnt_upd), 32'd1);
    chk("extest_mirror", 32'(mis), 32'd0);

    // BYPASS with TDI 1,0,1,1
    load_ir(4'b1111, irb);
    chk("bypass_capir", 32'(irb), 32'h1);
    chk("bypass_mode", 32'(ModeControl), 32'h0);
    clr_counts();
    dr_scan(4, 32'b1101, dro, mis, enl);
    chk("bypass_tdo", dro & 32'hF, 32'hA);
    chk("bypass_updbr", 32'(cnt_upd), 32'd0);

    // Reset during ShDR under EXTEST
    load_ir(4'b0000, irb);
    clr_counts();
    step(1, 0); step(0, 0); step(0, 1); step(0, 0); step(0, 1);
    chk("pre_rst_shift", 32'(ShiftBR), 32'h1);
    #2 Rst = 1'b1;
    #1;
    chk("midrst_state", 32'(TapState), 32'hF);
    chk("midrst_ir", 32'(IRValue), 32'h2);
    chk("midrst_outs", {26'd0, TDO, TDOEn, ShiftBR, ClockBREn, UpdateBR, ModeControl}, 32'h0);
    @(posedge ClockTAP); #1;
    Rst = 1'b0;
    step(0, 0); step(1, 0); step(1, 0);
    chk("midrst_noupd", 32'(cnt_upd), 32'd0);

    // Randomised traffic checked by the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        Rst = 1'b1; #2; Rst = 1'b0;
        @(posedge ClockTAP); #1;
      end else begin
        step($urandom_range(0, 99) < 35, 1'($urandom_range(0, 1)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tap_controller.md
TAP_CONTROLLER -- requirements
Module: tap_controller

Interface
REQ-001 Parameter IR_WIDTH, default 4: instruction register width.
REQ-002 Parameter IDCODE_VAL, default 32'h1000_0001: IDCODE value (bit 0 = 1).
REQ-003 ClockTAP  input  1  test clock; single clock domain, all state changes on its rising edge.
REQ-004 Rst  input  1  asynchronous, active-high reset.
REQ-005 TMS  input  1  test mode select, sampled on ClockTAP rise.
REQ-006 TDI  input  1  serial test data in, shared by IR and all DR paths.
REQ-007 BSRSOUT  input  1  SOUT of the last boundary-scan cell in the chain.
REQ-008 TDO  output  1  serial test data out.
REQ-009 TDOEn  output  1  TDO valid/drive enable.
REQ-010 ShiftBR  output  1  boundary-scan cell shift select (SIN vs DIN).
REQ-011 ClockBREn  output  1  enable for the external ClockBR gate; no clock gating inside this block.
REQ-012 UpdateBR  output  1  boundary-scan update strobe; the cell uses its rising edge as a clock.
REQ-013 ModeControl  output  1  boundary-scan cell output-mode select.
REQ-014 TapState  output  4  current TAP state encoding, for debug and verification.
REQ-015 IRValue  output  IR_WIDTH  active (updated) instruction.

Function
REQ-016 FSM SHALL implement the 16 IEEE 1149.1 TAP states with the standard TMS transitions.
REQ-017 State encoding SHALL be fixed as:
  - TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauDR=3, Ex2DR=0, UpdDR=5
  - SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauIR=B, Ex2IR=8, UpdIR=D
REQ-018 From any state, five consecutive TMS=1 cycles SHALL reach TLR.
REQ-019 IR shift register SHALL load 'b0..01 in CapIR and shift right in ShIR (TDI to MSB, LSB to TDO).
REQ-020 Active IR SHALL load from the shift register on the rising edge leaving UpdIR; it is held in all other states.
REQ-021 In TLR, active IR SHALL be forced to IDCODE.
REQ-022 Instruction decode SHALL be:
  - 0000 = EXTEST (BSR selected)
  - 0001 = SAMPLE/PRELOAD (BSR selected)
  - 0010 = IDCODE (32-bit ID register selected)
  - all other codes, including all-ones = BYPASS (1-bit bypass register selected)
REQ-023 Bypass register SHALL capture 0 in CapDR and load TDI in ShDR.
REQ-024 ID register SHALL capture IDCODE_VAL in CapDR and shift right in ShDR with TDI into bit 31.
REQ-025 TDOEn SHALL be 1 exactly in ShDR and ShIR; TDO SHALL be 0 whenever TDOEn=0.
REQ-026 TDO source SHALL be combinational:
  - IR shift LSB in ShIR
  - in ShDR: BSRSOUT when BSR selected, ID LSB when IDCODE, bypass bit otherwise
REQ-027 ShiftBR SHALL be 1 only in ShDR with BSR selected; it is 0 in CapDR, so cells capture DIN.
REQ-028 ClockBREn SHALL be 1 in CapDR and ShDR with BSR selected, else 0.
REQ-029 UpdateBR SHALL be 1 for exactly the cycle spent in UpdDR with BSR selected.
REQ-030 ShiftBR, ClockBREn, UpdateBR and ModeControl SHALL be registered, decoded from next state, and glitch-free.
REQ-031 ModeControl SHALL be 1 while the active IR is EXTEST, else 0; it changes only on IR update or TLR entry.
REQ-032 Pause states SHALL hold all shift registers; DR/IR contents are preserved across Pause and Exit2 resumption.

Reset
REQ-033 Rst=1 SHALL asynchronously force the following, independent of ClockTAP:
  - state to TLR, active IR to IDCODE, all shift registers to 0
  - ShiftBR, ClockBREn, UpdateBR, ModeControl, TDO, TDOEn to 0
REQ-034 Rst asserted mid-shift SHALL abort the scan; no UpdateBR pulse and no IR update occur.

Structure
REQ-035 State encodings, instruction opcodes and IR_WIDTH default SHALL live in shared package tap_pkg.
REQ-036 The block SHALL be a single module, with the FSM and data registers inline; no sub-module.

Verification
REQ-037 Bench SHALL cover these directed scenarios:
  - Reset, then TMS=1 x5 from RTI -> TapState=F, IRValue=0010, ModeControl=0, all BR controls 0.
  - TLR, TMS 0,1,0,0 then 32 ShDR cycles -> TDO emits 32'h1000_0001 LSB first, TDOEn=1 throughout.
  - Load IR=0000 (EXTEST) -> ModeControl rises after UpdIR; DR scan of N bits:
    - ClockBREn=1 for N+1 cycles, ShiftBR=1 for N cycles
    - one UpdateBR pulse of 1 cycle
    - TDO mirrors BSRSOUT.
  - Load IR=1111 and shift TDI pattern 1011 -> TDO = 0,1,0,1 (one-cycle bypass delay); UpdateBR stays 0.
  - CapIR then ShIR x4 -> TDO = 1,0,0,0.
  - Rst pulse during ShDR under EXTEST -> immediate TLR, outputs 0, no UpdateBR.
